// File: rtl/bf_top.sv
// Two-beam, 8-element transmit beamformer. Each element sums the real parts of both
// weighted beams and drives a first-order ternary delta-sigma modulator (3-level pwm code).
module bf_top #(
    parameter int N_ELEM  = 8,
    parameter int VIN_W   = 10,
    parameter int W_W     = 5,
    parameter int FS_LOG2 = 15,
    parameter int ACC_W   = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [VIN_W-1:0]     vin_i_1,
    input  logic signed [VIN_W-1:0]     vin_q_1,
    input  logic signed [VIN_W-1:0]     vin_i_2,
    input  logic signed [VIN_W-1:0]     vin_q_2,
    input  logic [N_ELEM-1:0][W_W-1:0]  w_cos_1,
    input  logic [N_ELEM-1:0][W_W-1:0]  w_sin_1,
    input  logic [N_ELEM-1:0][W_W-1:0]  w_cos_2,
    input  logic [N_ELEM-1:0][W_W-1:0]  w_sin_2,
    output logic [N_ELEM-1:0][1:0]      pwm
);
    localparam int P_W = VIN_W + W_W;
    localparam int S_W = P_W + 2;
    localparam logic signed [ACC_W-1:0] L_FS   = ACC_W'(2 ** FS_LOG2);
    localparam logic signed [ACC_W-1:0] L_HALF = ACC_W'(2 ** (FS_LOG2 - 1));

    localparam logic [1:0] C_POS  = 2'b01;
    localparam logic [1:0] C_NEG  = 2'b11;
    localparam logic [1:0] C_ZERO = 2'b00;

    // E1: captured samples and weights
    logic signed [VIN_W-1:0]     r_i1, r_q1, r_i2, r_q2;
    logic [N_ELEM-1:0][W_W-1:0]  r_wc1, r_ws1, r_wc2, r_ws2;
    // E2: products, E3: per-element sum, E4: modulator state
    logic [N_ELEM-1:0][P_W-1:0]  r_p0, r_p1, r_p2, r_p3;
    logic [N_ELEM-1:0][S_W-1:0]  r_s;
    logic [N_ELEM-1:0][ACC_W-1:0] r_acc;
    logic [N_ELEM-1:0][1:0]      r_pwm;

    logic [N_ELEM-1:0][P_W-1:0]  w_p0, w_p1, w_p2, w_p3;
    logic [N_ELEM-1:0][S_W-1:0]  w_s;
    logic [N_ELEM-1:0][ACC_W-1:0] w_vfs;
    logic [N_ELEM-1:0][ACC_W-1:0] w_acc_next;
    logic [N_ELEM-1:0][1:0]      w_pwm_next;

    function automatic logic [P_W-1:0] mul_sx(input logic [VIN_W-1:0] a,
                                              input logic [W_W-1:0] b);
        logic signed [P_W-1:0] a_x;
        logic signed [P_W-1:0] b_x;
        a_x = {{W_W{a[VIN_W-1]}}, a};
        b_x = {{VIN_W{b[W_W-1]}}, b};
        return a_x * b_x;
    endfunction

    function automatic logic [S_W-1:0] sx_p(input logic [P_W-1:0] p);
        return {{(S_W - P_W){p[P_W-1]}}, p};
    endfunction

    always_comb begin
        w_p0       = '0;
        w_p1       = '0;
        w_p2       = '0;
        w_p3       = '0;
        w_s        = '0;
        w_vfs      = '0;
        w_acc_next = '0;
        w_pwm_next = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            w_p0[k] = mul_sx(r_i1, r_wc1[k]);
            w_p1[k] = mul_sx(r_q1, r_ws1[k]);
            w_p2[k] = mul_sx(r_i2, r_wc2[k]);
            w_p3[k] = mul_sx(r_q2, r_ws2[k]);
            w_s[k]  = sx_p(r_p0[k]) - sx_p(r_p1[k]) + sx_p(r_p2[k]) - sx_p(r_p3[k]);

            // Feedback is the level currently on the pwm output, scaled to full scale.
            case (r_pwm[k])
                C_POS:   w_vfs[k] = L_FS;
                C_NEG:   w_vfs[k] = -L_FS;
                default: w_vfs[k] = '0;
            endcase
            w_acc_next[k] = r_acc[k] + {{(ACC_W - S_W){r_s[k][S_W-1]}}, r_s[k]} - w_vfs[k];

            if ($signed(w_acc_next[k]) >= L_HALF) begin
                w_pwm_next[k] = C_POS;
            end else if ($signed(w_acc_next[k]) <= -L_HALF) begin
                w_pwm_next[k] = C_NEG;
            end else begin
                w_pwm_next[k] = C_ZERO;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_i1  <= '0;
            r_q1  <= '0;
            r_i2  <= '0;
            r_q2  <= '0;
            r_wc1 <= '0;
            r_ws1 <= '0;
            r_wc2 <= '0;
            r_ws2 <= '0;
            r_p0  <= '0;
            r_p1  <= '0;
            r_p2  <= '0;
            r_p3  <= '0;
            r_s   <= '0;
            r_acc <= '0;
            r_pwm <= '0;
        end else begin
            r_i1  <= vin_i_1;
            r_q1  <= vin_q_1;
            r_i2  <= vin_i_2;
            r_q2  <= vin_q_2;
            r_wc1 <= w_cos_1;
            r_ws1 <= w_sin_1;
            r_wc2 <= w_cos_2;
            r_ws2 <= w_sin_2;
            r_p0  <= w_p0;
            r_p1  <= w_p1;
            r_p2  <= w_p2;
            r_p3  <= w_p3;
            r_s   <= w_s;
            r_acc <= w_acc_next;
            r_pwm <= w_pwm_next;
        end
    end

    assign pwm = r_pwm;

endmodule

// File: tb/tb_bf_top.sv
// Bench for bf_top: integer model of weighted sums plus delta-sigma rule, checked every
// cycle, with hand-computed expectations for reset, step, DC, cancellation and full scale.
module tb_bf_top;
    localparam int N  = 8;
    localparam int FS = 32768;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic signed [9:0]      vin_i_1, vin_q_1, vin_i_2, vin_q_2;
    logic [N-1:0][4:0]      w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic [N-1:0][1:0]      pwm;

    int n_vec  = 0;
    int n_fail = 0;

    int m_acc [N];
    int m_v   [N];
    int s_q   [$];

    bf_top dut (
        .clock   (clock),
        .reset   (reset),
        .vin_i_1 (vin_i_1),
        .vin_q_1 (vin_q_1),
        .vin_i_2 (vin_i_2),
        .vin_q_2 (vin_q_2),
        .w_cos_1 (w_cos_1),
        .w_sin_1 (w_sin_1),
        .w_cos_2 (w_cos_2),
        .w_sin_2 (w_sin_2),
        .pwm     (pwm)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Weighted real-part sum for element k from the inputs as currently driven.
    function automatic int spec_s(input int k);
        return int'(vin_i_1) * int'($signed(w_cos_1[k])) - int'(vin_q_1) * int'($signed(w_sin_1[k]))
             + int'(vin_i_2) * int'($signed(w_cos_2[k])) - int'(vin_q_2) * int'($signed(w_sin_2[k]));
    endfunction

    function automatic int pv(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
    endfunction

    function automatic logic [N-1:0][1:0] model_pwm();
        logic [N-1:0][1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k] = (m_v[k] == 1) ? 2'b01 : (m_v[k] == -1) ? 2'b11 : 2'b00;
        end
        return r;
    endfunction

    // Sums sampled at an edge reach the modulator three edges later: a FIFO primed with
    // three cycles of zeros (one entry per element per cycle) expresses that latency.
    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_acc[k] = 0;
            m_v[k]   = 0;
        end
        s_q.delete();
        repeat (3 * N) s_q.push_back(0);
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_clear();
        end else begin
            for (int k = 0; k < N; k++) begin
                int s_use;
                s_use = s_q.pop_front();
                s_q.push_back(spec_s(k));
                m_acc[k] = m_acc[k] + s_use - m_v[k] * FS;
                m_v[k]   = (m_acc[k] >= FS / 2) ? 1 : (m_acc[k] <= -FS / 2) ? -1 : 0;
            end
        end
    end

    always @(negedge clock) begin
        check("model_pwm", int'(pwm), int'(model_pwm()));
    end

    task automatic clear_in();
        vin_i_1 = '0;
        vin_q_1 = '0;
        vin_i_2 = '0;
        vin_q_2 = '0;
        w_cos_1 = '0;
        w_sin_1 = '0;
        w_cos_2 = '0;
        w_sin_2 = '0;
    endtask

    task automatic rand_w();
        for (int k = 0; k < N; k++) begin
            w_cos_1[k] = 5'($urandom_range(0, 31));
            w_sin_1[k] = 5'($urandom_range(0, 31));
            w_cos_2[k] = 5'($urandom_range(0, 31));
            w_sin_2[k] = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic rand_in();
        vin_i_1 = 10'($urandom_range(0, 1023));
        vin_q_1 = 10'($urandom_range(0, 1023));
        vin_i_2 = 10'($urandom_range(0, 1023));
        vin_q_2 = 10'($urandom_range(0, 1023));
        rand_w();
    endtask

    // Leaves the bench at a falling edge with reset just released and inputs zeroed.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_in();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        int sum [N];
        logic [N-1:0][1:0] all_pos;

        model_clear();
        clear_in();
        for (int k = 0; k < N; k++) all_pos[k] = 2'b01;
        #1 reset = 1'b1;

        // Reset held while inputs toggle randomly.
        repeat (10) begin
            @(negedge clock);
            rand_in();
            check("rst_hold", int'(pwm), 0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (300) begin
            rand_in();
            @(negedge clock);
        end

        // Step on element 0: s = 16384 gives 00,00,00 then 01, then alternating density 1/2.
        do_reset();
        vin_i_1    = -10'sd512;
        vin_i_2    = -10'sd512;
        w_cos_1[0] = 5'b10000;
        w_cos_2[0] = 5'b10000;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock);
            #1 check("step_latency", int'(pwm[0]), 0);
        end
        @(posedge clock);
        #1 check("step_edge4", int'(pwm[0]), 1);
        cnt = 0;
        repeat (1000) begin
            cnt += pv(pwm[0]);
            @(posedge clock);
            #1;
        end
        check_rng("step_density", cnt, 498, 502);

        // DC negative on every element: s = -7680.
        do_reset();
        vin_i_1 = -10'sd512;
        for (int k = 0; k < N; k++) w_cos_1[k] = 5'd15;
        repeat (3) @(posedge clock);
        bad = 0;
        for (int k = 0; k < N; k++) sum[k] = 0;
        repeat (32768) begin
            @(posedge clock);
            #1;
            for (int k = 0; k < N; k++) begin
                sum[k] += pv(pwm[k]);
                if (pwm[k] == 2'b10) bad++;
            end
        end
        for (int k = 0; k < N; k++) check_rng("dc_neg_sum", sum[k], -7682, -7678);
        check("dc_no_code10", bad, 0);

        // Zero inputs with arbitrary weights stay silent.
        do_reset();
        rand_w();
        bad = 0;
        repeat (10000) begin
            @(negedge clock);
            if (pwm != '0) bad++;
        end
        check("zero_in_silent", bad, 0);

        // Beam 2 cancels beam 1.
        do_reset();
        vin_i_1 = 10'sd300;
        vin_i_2 = -10'sd300;
        for (int k = 0; k < N; k++) begin
            w_cos_1[k] = 5'd13;
            w_cos_2[k] = 5'd13;
        end
        bad = 0;
        repeat (200) begin
            @(negedge clock);
            if (pwm != '0) bad++;
        end
        check("cancel_silent", bad, 0);

        // Largest reachable sum (+16 is not a 5-bit weight, so q = +511, ws = -16):
        // s = 8192 + 8176 + 8192 + 8176 = 32736 keeps pwm at +1 for several hundred cycles.
        do_reset();
        vin_i_1 = -10'sd512;
        vin_i_2 = -10'sd512;
        vin_q_1 = 10'sd511;
        vin_q_2 = 10'sd511;
        for (int k = 0; k < N; k++) begin
            w_cos_1[k] = 5'b10000;
            w_cos_2[k] = 5'b10000;
            w_sin_1[k] = 5'b10000;
            w_sin_2[k] = 5'b10000;
        end
        repeat (3) @(posedge clock);
        #1 check("fs_pre_latency", int'(pwm), 0);
        bad = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (pwm != all_pos) bad++;
        end
        check("fs_all_pos", bad, 0);

        // Asynchronous reset mid-stream clears pwm without a clock edge.
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("async_reset", int'(pwm), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock);
            #1 check("post_rst_latency", int'(pwm), 0);
        end
        @(posedge clock);
        #1 check("post_rst_edge4", int'(pwm), int'(all_pos));
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
